sprite_rom_arbiter: RTL and testbench

Shares one combinational sprite bitmap ROM (256 x 8, 8-bit address: 3-bit bitmap index plus 5-bit row/half) between up to NREQ sprite renderers, so several tank controllers can draw from a single ROM instance. Each requester posts a request with an address. A round-robin arbiter issues one ROM address per cycle and returns the registered data to the owner with a one-cycle valid pulse. The block also flags any requester that waits too long for a grant. It sits between the tank controllers and the bitmap ROM in the top level.

---
 rtl/sprite_pkg.sv | 19 +
 rtl/rr_select.sv | 35 +++
 rtl/sprite_rom_arbiter.sv | 99 +++++++++
 tb/tb_sprite_rom_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// ROM geometry shared by the sprite renderers and the ROM arbiter,
// plus a ceiling-log2 helper for sizing pointers and counters.
package sprite_pkg;

  localparam int ROM_AW          = 8;
  localparam int ROM_DW          = 8;
  localparam int ROWS_PER_BITMAP = 16;
  localparam int NUM_BITMAPS     = 5;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: the first requester found when searching
// from rr_ptr upwards (modulo NREQ) wins. Reused by the playfield bus arbiter.
module rr_select #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   winner,
  output logic            any
);

  int            sum;
  logic [PW-1:0] idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    sum    = 0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = PW'(sum);
      if (!any && req[idx]) begin
        any         = 1'b1;
        grant[idx]  = 1'b1;
        winner      = idx;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one combinational sprite ROM between NREQ renderers: round-robin
// address issue, registered data return with a one-cycle rvalid, starvation flags.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int AW       = ROM_AW,
  parameter int DW       = ROM_DW,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]  grant,
  output logic [NREQ-1:0]  rvalid,
  output logic [DW-1:0]    rdata,
  output logic [AW-1:0]    rom_addr,
  input  logic [DW-1:0]    rom_bits,
  output logic [NREQ-1:0]  starve
);

  localparam int            PW         = clog2(NREQ);
  localparam int            CW         = clog2(MAX_WAIT + 2);
  localparam logic [PW-1:0] LAST_IDX   = PW'(NREQ - 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(MAX_WAIT);

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   owner;
  logic [NREQ-1:0] sel_grant;
  logic            sel_any;
  logic            stage_valid;
  logic [CW-1:0]   wait_cnt [NREQ];

  rr_select #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_select (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (sel_grant),
    .winner (winner),
    .any    (sel_any)
  );

  // Grant is masked while in reset so nothing is promised that would be dropped.
  assign grant = sel_grant & {NREQ{reset_n}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr      <= '0;
      rom_addr    <= '0;
      owner       <= '0;
      stage_valid <= 1'b0;
    end else begin
      stage_valid <= sel_any;
      if (sel_any) begin
        rom_addr <= req_addr[int'(winner)*AW +: AW];
        owner    <= winner;
        rr_ptr   <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata  <= '0;
      rvalid <= '0;
    end else begin
      rvalid <= '0;
      if (stage_valid) begin
        rdata         <= rom_bits;
        rvalid[owner] <= 1'b1;
      end
    end
  end

  // A requester starves on the edge its count would reach MAX_WAIT+1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREQ; i++) wait_cnt[i] <= '0;
      starve <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] || sel_grant[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != WAIT_LIMIT) begin
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
        if (req[i] && !sel_grant[i] && (wait_cnt[i] == WAIT_LAST)) begin
          starve[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed scenarios plus randomized traffic,
// checked each cycle against a transaction-level reference model.
module tb_sprite_rom_arbiter;

  localparam int NREQ     = 4;
  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int MAX_WAIT = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   rvalid;
  logic [DW-1:0]     rdata;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_bits;
  logic [NREQ-1:0]   starve;

  sprite_rom_arbiter #(
    .NREQ     (NREQ),
    .AW       (AW),
    .DW       (DW),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_addr (req_addr),
    .grant    (grant),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .rom_addr (rom_addr),
    .rom_bits (rom_bits),
    .starve   (starve)
  );

  always #5 clk = ~clk;

  // ROM model: each location holds the inverse of its address.
  assign rom_bits = ~rom_addr;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: accepted reads become transactions due two cycles later.
  typedef struct {
    int         owner;
    logic [7:0] addr;
    int         due;
  } txn_t;

  txn_t        pend[$];
  int          cyc = 0;
  int          m_ptr = 0;
  int          waited[NREQ];
  logic [3:0]  m_starve = '0;
  logic [7:0]  m_last_addr = '0;

  task automatic model_clear();
    pend.delete();
    m_ptr       = 0;
    m_starve    = '0;
    m_last_addr = '0;
    for (int i = 0; i < NREQ; i++) waited[i] = 0;
  endtask

  task automatic model_cycle();
    int         w;
    int         j;
    logic [3:0] exp_g;
    logic [3:0] exp_rv;
    logic [7:0] exp_rd;
    logic [7:0] gaddr;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (w < 0 && req[j]) w = j;
    end
    exp_g  = (w >= 0) ? (4'b0001 << w) : 4'b0000;
    exp_rv = 4'b0000;
    exp_rd = 8'h00;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rv = 4'b0001 << pend[0].owner;
      exp_rd = ~pend[0].addr;
      void'(pend.pop_front());
    end
    check_val($sformatf("grant@%0d", cyc), grant, exp_g);
    check_val($sformatf("rvalid@%0d", cyc), rvalid, exp_rv);
    if (exp_rv != 0) check_val($sformatf("rdata@%0d", cyc), rdata, exp_rd);
    check_val($sformatf("rom_addr@%0d", cyc), rom_addr, m_last_addr);
    check_val($sformatf("starve@%0d", cyc), starve, m_starve);
    if (w >= 0) begin
      gaddr = 8'(req_addr >> (8 * w));
      pend.push_back('{w, gaddr, cyc + 2});
      m_last_addr = gaddr;
      m_ptr       = (w + 1) % NREQ;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && i != w) waited[i]++;
      else waited[i] = 0;
      if (waited[i] >= MAX_WAIT + 1) m_starve[i] = 1'b1;
    end
    cyc++;
  endtask

  // Called just after a rising edge; leaves time just after the next one.
  task automatic cycle(input logic [3:0] r, input logic [31:0] a);
    req      = r;
    req_addr = a;
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check_val({tag, "_grant"}, grant, 0);
    check_val({tag, "_rvalid"}, rvalid, 0);
    check_val({tag, "_starve"}, starve, 0);
    check_val({tag, "_rdata"}, rdata, 0);
    check_val({tag, "_rom_addr"}, rom_addr, 0);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  logic [3:0]  r_rand;
  logic [31:0] a_rand;
  logic [3:0]  prev_req;

  initial begin
    reset_n  = 1'b0;
    req      = '0;
    req_addr = '0;
    model_clear();
    @(posedge clk);
    #1;
    apply_reset("por");

    // Single requester: address 0x45 reads back 0xBA two edges after grant.
    cycle(4'b0100, 32'h0045_0000);
    cycle(4'b0000, 32'h0045_0000);
    check_val("single_rvalid", rvalid, 4'b0100);
    check_val("single_rdata", rdata, 8'hBA);
    cycle(4'b0000, 32'h0045_0000);

    // All four requesting: rotation 0,1,2,3,0 and starvation with MAX_WAIT=2.
    apply_reset("rot");
    for (int n = 0; n < 5; n++) cycle(4'b1111, 32'hD4C3_B2A1);
    cycle(4'b0000, 32'hD4C3_B2A1);
    cycle(4'b0000, 32'hD4C3_B2A1);
    check_val("starve_sticky", starve, 4'b1011);
    cycle(4'b0000, 32'hD4C3_B2A1);
    check_val("starve_held", starve, 4'b1011);

    // Pointer at 1 with req=1001: grant 3 first, then 0.
    apply_reset("ptr");
    cycle(4'b0001, 32'h1100_0022);
    req = 4'b1001;
    #1;
    check_val("ptr1_first", grant, 4'b1000);
    cycle(4'b1001, 32'h1100_0022);
    check_val("ptr1_second", grant, 4'b0001);
    cycle(4'b1001, 32'h1100_0022);
    cycle(4'b0000, 32'h1100_0022);
    cycle(4'b0000, 32'h1100_0022);

    // Withdraw: requester 1 drops out while 0 is being serviced.
    apply_reset("wd");
    cycle(4'b0011, 32'h0000_5A66);
    cycle(4'b0001, 32'h0000_5A66);
    for (int n = 0; n < 3; n++) cycle(4'b0000, 32'h0000_5A66);

    // Reset between a grant and its rvalid.
    cycle(4'b1111, 32'h4433_2211);
    apply_reset("midflight");
    cycle(4'b1111, 32'h4433_2211);
    cycle(4'b0000, 32'h4433_2211);
    cycle(4'b0000, 32'h4433_2211);

    // Randomized traffic with periodic resets to keep starvation meaningful.
    for (int round = 0; round < 4; round++) begin
      apply_reset($sformatf("rnd%0d", round));
      prev_req = '0;
      a_rand   = $urandom;
      for (int n = 0; n < 60; n++) begin
        for (int i = 0; i < NREQ; i++) begin
          r_rand[i] = ($urandom_range(0, 9) < 6);
          if (!prev_req[i]) a_rand[i*8 +: 8] = 8'($urandom_range(0, 255));
        end
        cycle(r_rand, a_rand);
        prev_req = r_rand;
      end
      cycle(4'b0000, a_rand);
      cycle(4'b0000, a_rand);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
